// File: rtl/rw_writeback.sv
// Writeback stage: merges in-order load responses and ALU results onto one
// register-file write port, tracks outstanding load destinations for hazards.
module rw_writeback #(
  parameter int LOAD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  input  logic [3:0]  exe_addr,
  input  logic [31:0] exe_data,
  output logic        exe_ready,
  input  logic        ld_issue_valid,
  input  logic [3:0]  ld_issue_addr,
  output logic        ld_issue_ready,
  input  logic        ld_resp_valid,
  input  logic [31:0] ld_resp_data,
  output logic [3:0]  write_addr,
  output logic [31:0] write_data,
  output logic [3:0]  fwd_addr,
  output logic [31:0] fwd_data,
  input  logic [3:0]  rd_a_addr,
  input  logic [3:0]  rd_b_addr,
  output logic        stall,
  output logic        resp_err
);

  localparam int              PTR_W    = $clog2(LOAD_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(LOAD_DEPTH);

  typedef enum logic [1:0] {SEL_NONE, SEL_LOAD, SEL_SKID, SEL_EXE} wr_sel_e;

  logic [3:0]       fifo_mem [LOAD_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [15:0]      busy, busy_next;
  logic             skid_valid;
  logic [3:0]       skid_addr;
  logic [31:0]      skid_data;

  logic       fifo_full, fifo_empty;
  logic [3:0] head;
  logic       issue_fire, exe_fire, resp_pop, resp_drop;
  wr_sel_e    wr_sel;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];

  assign ld_issue_ready = !rst && !fifo_full && !busy[ld_issue_addr];
  assign exe_ready      = !rst && !skid_valid && ((exe_addr == 4'd0) || !busy[exe_addr]);

  assign issue_fire = ld_issue_valid && ld_issue_ready;
  assign exe_fire   = exe_valid && exe_ready;
  assign resp_pop   = ld_resp_valid && !fifo_empty;
  assign resp_drop  = ld_resp_valid && fifo_empty;

  assign fwd_addr = exe_fire ? exe_addr : 4'd0;
  assign fwd_data = exe_fire ? exe_data : 32'd0;

  function automatic logic src_hazard(input logic [3:0] addr);
    return (addr != 4'd0) && (busy[addr] || (skid_valid && (skid_addr == addr)));
  endfunction

  assign stall = src_hazard(rd_a_addr) || src_hazard(rd_b_addr);

  // NOTE: every signal written in always_comb gets a default first; otherwise a missed branch infers a latch.
  always_comb begin
    busy_next = busy;
    if (resp_pop)   busy_next[head]          = 1'b0;
    if (issue_fire) busy_next[ld_issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Load response always wins; a skid entry waits behind it, a fresh ALU result last.
  always_comb begin
    wr_sel = SEL_NONE;
    if (resp_pop)        wr_sel = SEL_LOAD;
    else if (skid_valid) wr_sel = SEL_SKID;
    else if (exe_fire)   wr_sel = SEL_EXE;
  end

  // NOTE: the address storage has no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (issue_fire) fifo_mem[wr_ptr] <= ld_issue_addr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy       <= '0;
      skid_valid <= 1'b0;
      skid_addr  <= 4'd0;
      skid_data  <= 32'd0;
      write_addr <= 4'd0;
      write_data <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      busy <= busy_next;
      if (issue_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (resp_pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({issue_fire, resp_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      if (resp_drop) resp_err <= 1'b1;

      // exe_fire implies the skid is empty, so a losing ALU result always has room.
      if (resp_pop && exe_fire) begin
        skid_valid <= 1'b1;
        skid_addr  <= exe_addr;
        skid_data  <= exe_data;
      end else if (wr_sel == SEL_SKID) begin
        skid_valid <= 1'b0;
      end

      case (wr_sel)
        SEL_LOAD: begin
          write_addr <= head;
          write_data <= ld_resp_data;
        end
        SEL_SKID: begin
          write_addr <= skid_addr;
          write_data <= skid_data;
        end
        SEL_EXE: begin
          write_addr <= exe_addr;
          write_data <= exe_data;
        end
        default: write_addr <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_rw_writeback.sv
// Directed bench for rw_writeback: a table of per-cycle vectors with expected
// combinational and registered outputs, plus a hand-written mid-load reset sequence.
module tb_rw_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid;
  logic [3:0]  exe_addr;
  logic [31:0] exe_data;
  logic        exe_ready;
  logic        ld_issue_valid;
  logic [3:0]  ld_issue_addr;
  logic        ld_issue_ready;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [3:0]  rd_a_addr;
  logic [3:0]  rd_b_addr;
  logic        stall;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  rw_writeback #(.LOAD_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .exe_addr(exe_addr), .exe_data(exe_data), .exe_ready(exe_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_addr(ld_issue_addr), .ld_issue_ready(ld_issue_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .write_addr(write_addr), .write_data(write_data),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .stall(stall), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ev;
    logic [3:0]  ea;
    logic [31:0] ed;
    logic        iv;
    logic [3:0]  ia;
    logic        rv;
    logic [31:0] rdat;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        x_er;
    logic        x_lir;
    logic        x_stall;
    logic [3:0]  x_fa;
    logic [31:0] x_fd;
    logic [3:0]  x_wa;
    logic [31:0] x_wd;
    logic        x_err;
  } vec_t;

  function automatic vec_t v(
    input logic ev, input logic [3:0] ea, input logic [31:0] ed,
    input logic iv, input logic [3:0] ia,
    input logic rv, input logic [31:0] rdat,
    input logic [3:0] ra, input logic [3:0] rb,
    input logic x_er, input logic x_lir, input logic x_stall,
    input logic [3:0] x_fa, input logic [31:0] x_fd,
    input logic [3:0] x_wa, input logic [31:0] x_wd, input logic x_err);
    vec_t r;
    r.ev = ev; r.ea = ea; r.ed = ed; r.iv = iv; r.ia = ia; r.rv = rv; r.rdat = rdat;
    r.ra = ra; r.rb = rb; r.x_er = x_er; r.x_lir = x_lir; r.x_stall = x_stall;
    r.x_fa = x_fa; r.x_fd = x_fd; r.x_wa = x_wa; r.x_wd = x_wd; r.x_err = x_err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    exe_valid = 1'b0; exe_addr = 4'd0; exe_data = 32'd0;
    ld_issue_valid = 1'b0; ld_issue_addr = 4'd0;
    ld_resp_valid = 1'b0; ld_resp_data = 32'd0;
    rd_a_addr = 4'd0; rd_b_addr = 4'd0;
  endtask

  // Entered just after a rising edge: drive, sample combinational outputs
  // mid-cycle, then sample registered outputs just after the next edge.
  task automatic apply(input int idx, input vec_t t);
    exe_valid = t.ev; exe_addr = t.ea; exe_data = t.ed;
    ld_issue_valid = t.iv; ld_issue_addr = t.ia;
    ld_resp_valid = t.rv; ld_resp_data = t.rdat;
    rd_a_addr = t.ra; rd_b_addr = t.rb;
    #3;
    check($sformatf("row%0d exe_ready", idx), 32'(exe_ready), 32'(t.x_er));
    check($sformatf("row%0d ld_issue_ready", idx), 32'(ld_issue_ready), 32'(t.x_lir));
    check($sformatf("row%0d stall", idx), 32'(stall), 32'(t.x_stall));
    check($sformatf("row%0d fwd_addr", idx), 32'(fwd_addr), 32'(t.x_fa));
    check($sformatf("row%0d fwd_data", idx), fwd_data, t.x_fd);
    @(posedge clk);
    #1;
    check($sformatf("row%0d write_addr", idx), 32'(write_addr), 32'(t.x_wa));
    check($sformatf("row%0d write_data", idx), write_data, t.x_wd);
    check($sformatf("row%0d resp_err", idx), 32'(resp_err), 32'(t.x_err));
  endtask

  vec_t vecs[$];

  initial begin
    // ALU-only back-to-back, latency 1, then write_data holds on an idle cycle
    vecs.push_back(v(1, 3, 'h11,  0, 0, 0, 0,  0, 0,  1, 1, 0,  3, 'h11,  3, 'h11, 0));
    vecs.push_back(v(1, 4, 'h22,  0, 0, 0, 0,  0, 0,  1, 1, 0,  4, 'h22,  4, 'h22, 0));
    vecs.push_back(v(0, 0, 0,     0, 0, 0, 0,  0, 0,  1, 1, 0,  0, 0,     0, 'h22, 0));
    // Load/ALU conflict: load r6 wins, r5 goes to skid, drains next cycle
    vecs.push_back(v(0, 0, 0,     1, 6, 0, 0,     0, 0,  1, 1, 0,  0, 0,     0, 'h22, 0));
    vecs.push_back(v(1, 5, 'hAA,  0, 0, 1, 'hBB,  0, 0,  1, 1, 0,  5, 'hAA,  6, 'hBB, 0));
    vecs.push_back(v(1, 9, 'h99,  0, 0, 0, 0,     5, 0,  0, 1, 1,  0, 0,     5, 'hAA, 0));
    vecs.push_back(v(1, 9, 'h99,  0, 0, 0, 0,     5, 0,  1, 1, 0,  9, 'h99,  9, 'h99, 0));
    // Hazard on r7 until its load data is written
    vecs.push_back(v(0, 0, 0,     1, 7, 0, 0,     7, 0,  1, 1, 0,  0, 0,     0, 'h99, 0));
    vecs.push_back(v(1, 7, 'h70,  0, 0, 0, 0,     7, 0,  0, 1, 1,  0, 0,     0, 'h99, 0));
    vecs.push_back(v(1, 7, 'h70,  0, 0, 1, 'h77,  0, 7,  0, 1, 1,  0, 0,     7, 'h77, 0));
    vecs.push_back(v(1, 7, 'h70,  0, 0, 0, 0,     7, 0,  1, 1, 0,  7, 'h70,  7, 'h70, 0));
    // Fill the queue with r1..r4
    for (int k = 1; k <= 4; k++)
      vecs.push_back(v(0, 0, 0,   1, 4'(k), 0, 0,  0, 0,  1, 1, 0,  0, 0,  0, 'h70, 0));
    vecs.push_back(v(0, 0, 0,     1, 8, 0, 0,     3, 0,  1, 0, 1,  0, 0,     0, 'h70, 0));
    vecs.push_back(v(0, 0, 0,     1, 8, 1, 'h01,  0, 0,  1, 0, 0,  0, 0,     1, 'h01, 0));
    vecs.push_back(v(0, 0, 0,     1, 8, 0, 0,     0, 0,  1, 1, 0,  0, 0,     0, 'h01, 0));
    // Drain through wrap; issue to a busy register is refused, addr 0 is queued
    vecs.push_back(v(0, 0, 0,     0, 0, 1, 'h02,  0, 0,  1, 0, 0,  0, 0,     2, 'h02, 0));
    vecs.push_back(v(1, 3, 'h33,  1, 3, 0, 0,     0, 0,  0, 0, 0,  0, 0,     0, 'h02, 0));
    vecs.push_back(v(0, 0, 0,     1, 3, 1, 'h03,  0, 0,  1, 0, 0,  0, 0,     3, 'h03, 0));
    vecs.push_back(v(0, 0, 0,     1, 0, 1, 'h04,  0, 0,  1, 1, 0,  0, 0,     4, 'h04, 0));
    vecs.push_back(v(0, 0, 0,     0, 0, 1, 'h08,  0, 0,  1, 1, 0,  0, 0,     8, 'h08, 0));
    vecs.push_back(v(0, 0, 0,     0, 0, 1, 'h5A,  0, 0,  1, 1, 0,  0, 0,     0, 'h5A, 0));
    // Response with the queue empty: dropped, sticky error
    vecs.push_back(v(0, 0, 0,     0, 0, 1, 'hDEAD, 0, 0, 1, 1, 0,  0, 0,     0, 'h5A, 1));
    vecs.push_back(v(1, 10, 'h10, 0, 0, 0, 0,     0, 0,  1, 1, 0,  10, 'h10, 10, 'h10, 1));

    drive_idle();
    rst = 1'b1;
    exe_valid = 1'b1; exe_addr = 4'd2; exe_data = 32'h1234;
    ld_issue_valid = 1'b1; ld_issue_addr = 4'd2;
    #2;
    check("reset exe_ready", 32'(exe_ready), 32'd0);
    check("reset ld_issue_ready", 32'(ld_issue_ready), 32'd0);
    check("reset fwd_addr", 32'(fwd_addr), 32'd0);
    check("reset write_addr", 32'(write_addr), 32'd0);
    check("reset write_data", write_data, 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    drive_idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Reset in the middle of two outstanding loads
    drive_idle();
    ld_issue_valid = 1'b1; ld_issue_addr = 4'd11;
    @(posedge clk); #1;
    ld_issue_addr = 4'd12;
    @(posedge clk); #1;
    drive_idle();
    rd_a_addr = 4'd11;
    #1;
    check("pre-reset stall", 32'(stall), 32'd1);
    exe_valid = 1'b1; exe_addr = 4'd5; exe_data = 32'h55;
    ld_issue_addr = 4'd11;
    rst = 1'b1;
    #1;
    check("midreset write_addr", 32'(write_addr), 32'd0);
    check("midreset write_data", write_data, 32'd0);
    check("midreset resp_err", 32'(resp_err), 32'd0);
    check("midreset exe_ready", 32'(exe_ready), 32'd0);
    check("midreset ld_issue_ready", 32'(ld_issue_ready), 32'd0);
    check("midreset fwd_data", fwd_data, 32'd0);
    check("midreset stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    rd_a_addr = 4'd11; ld_issue_addr = 4'd11;
    ld_resp_valid = 1'b1; ld_resp_data = 32'hCAFE;
    #1;
    check("postreset stall", 32'(stall), 32'd0);
    check("postreset ld_issue_ready", 32'(ld_issue_ready), 32'd1);
    @(posedge clk); #1;
    check("stale resp write_addr", 32'(write_addr), 32'd0);
    check("stale resp write_data", write_data, 32'd0);
    check("stale resp resp_err", 32'(resp_err), 32'd1);
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rw_writeback.md
RW_WRITEBACK -- requirements
Module: rw_writeback

Interface
REQ-001 SHALL have parameter LOAD_DEPTH, default 4, maximum outstanding loads (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port exe_valid  input  1  ALU result offered.
REQ-005 SHALL have port exe_addr  input  4  ALU destination register.
REQ-006 SHALL have port exe_data  input  32  ALU result value.
REQ-007 SHALL have port exe_ready  output  1  ALU result accepted this cycle when high with exe_valid.
REQ-008 SHALL have port ld_issue_valid  input  1  load issued to memory.
REQ-009 SHALL have port ld_issue_addr  input  4  load destination register.
REQ-010 SHALL have port ld_issue_ready  output  1  load issue accepted when high with ld_issue_valid.
REQ-011 SHALL have port ld_resp_valid  input  1  load data returned, in issue order, no back-pressure.
REQ-012 SHALL have port ld_resp_data  input  32  returned load value.
REQ-013 SHALL have ports write_addr  output  4  and write_data  output  32, the register-file write port; write_addr 0 = no write.
REQ-014 SHALL have ports fwd_addr  output  4  and fwd_data  output  32, the execute bypass to the register file.
REQ-015 SHALL have ports rd_a_addr, rd_b_addr  input  4 each  source registers of the decoding instruction.
REQ-016 SHALL have port stall  output  1  decoding instruction must wait.
REQ-017 SHALL have port resp_err  output  1  sticky: load response arrived with empty queue.

Function
REQ-018 SHALL keep a LOAD_DEPTH-entry FIFO of load destination addresses and a 16-bit busy vector; busy[0] SHALL always read 0.
REQ-019 ld_issue_ready SHALL be high iff FIFO not full (pre-pop count) and busy[ld_issue_addr]==0.
REQ-020 An accepted issue SHALL push ld_issue_addr (including addr 0) and set busy[addr] for addr!=0 at the next edge.
REQ-021 ld_resp_valid with FIFO non-empty SHALL pop the head and register write_addr=head, write_data=ld_resp_data at that edge, clearing busy[head].
REQ-022 ld_resp_valid with FIFO empty SHALL be dropped and set resp_err; FIFO and busy unchanged.
REQ-023 SHALL keep a one-entry skid register (valid, addr, data) for ALU results.
REQ-024 exe_ready SHALL be high iff skid empty and (exe_addr==0 or busy[exe_addr]==0).
REQ-025 Write-port priority each edge: load response, then skid, then newly accepted ALU result; loser ALU result goes to skid.
REQ-026 Accepted ALU result with no load response SHALL appear on write_addr/write_data one cycle after acceptance (latency 1).
REQ-027 Skid SHALL drain on the first edge without a valid load response; exe_ready SHALL stay low while skid valid.
REQ-028 When no write is selected, write_addr SHALL be 0 and write_data SHALL hold its previous value.
REQ-029 fwd_addr/fwd_data SHALL combinationally equal exe_addr/exe_data when exe_valid&exe_ready, else 0/0.
REQ-030 stall SHALL be high iff some rd_x_addr!=0 has busy[rd_x_addr]==1 or equals skid addr with skid valid.
REQ-031 Simultaneous issue and response SHALL both take effect; pointers wrap modulo LOAD_DEPTH.

Reset
REQ-032 rst SHALL asynchronously clear FIFO, busy, skid valid and resp_err, and force write_addr=0, write_data=0.
REQ-033 While rst is high exe_ready and ld_issue_ready SHALL be 0; reset mid-load SHALL discard outstanding loads, and later responses SHALL set resp_err.

Verification
REQ-034 ALU only: exe r3=0x11 then r4=0x22 on back-to-back cycles -> write_addr 3/data 0x11, then 4/0x22, one cycle after each; fwd mirrors inputs.
REQ-035 Conflict: ALU r5=0xAA in the same cycle as load response for r6=0xBB -> r6/0xBB written first, r5/0xAA next cycle, exe_ready low that next cycle.
REQ-036 Hazard: issue load to r7, decode rd_a=7 -> stall=1 and ALU to r7 not accepted until response 0x77 written; stall=0 the cycle after.
REQ-037 Full: 4 loads to r1..r4 -> ld_issue_ready=0; response with issue to r8 same cycle -> r1 written, r8 rejected that cycle, accepted next.
REQ-038 Errors: response with empty FIFO -> resp_err=1, no write; rst mid-operation -> all outputs 0, busy clear, resp_err 0.
